serial_alu_seq: RTL and testbench
=================================

Name: serial_alu_seq

Overview:
- Bit-serial execute stage directly downstream of the serial register file.
- Consumes rs1_bit/rs2_bit LSB-first and drives shift_en.
- Computes one result bit per cycle and returns it as wr_bit/wr_en for writeback into rd.
- Sequences exactly REG_WIDTH shift cycles per operation and latches ZCN flags for the branch/control logic.

Parameters:
REG_WIDTH, 8, operand width in bits; equals number of shift cycles per op
CNT_W, $clog2(REG_WIDTH), bit-counter width (derived; not overridden)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request op; accepted only in IDLE
op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV (pass rs1), 110 CMP, 111 ADC/NOP (see Optional Feature)
rs1_bit  input  1  current operand-A bit from regfile, LSB-first
rs2_bit  input  1  current operand-B bit from regfile, LSB-first
shift_en  output  1  advance regfile one bit
wr_bit  output  1  current result bit
wr_en  output  1  write wr_bit into rd this cycle
busy  output  1  high from accept until done cycle inclusive
done  output  1  one-cycle pulse, op complete, flags valid
flag_z  output  1  result == 0
flag_c  output  1  carry out (SUB/CMP: 1 = no borrow)
flag_n  output  1  result MSB

Behaviour:
- FSM states: IDLE, EXEC, DONE.
- IDLE: start=1 -> EXEC; latch op; clear bit counter.
  - Preset carry register: 1 for SUB/CMP, 0 otherwise; ADC uses flag_c.
  - Set zero-accumulator to 1.
- EXEC: shift_en=1 every cycle; counter increments 0..REG_WIDTH-1; at count REG_WIDTH-1 -> DONE.
- DONE: done=1 for one cycle; shift_en=0 -> IDLE.
- start in EXEC or DONE is ignored; no queuing.
- Latency: start sampled high at edge T -> EXEC cycles T+1..T+REG_WIDTH -> done high in cycle T+REG_WIDTH+1 -> next start accepted in cycle T+REG_WIDTH+2.
- Total shifts per op always exactly REG_WIDTH, so regfile rotation returns to alignment.
- wr_bit is combinational from rs1_bit, rs2_bit, carry register and latched op:
  - ADD: a^b^c.
  - SUB/CMP: a^~b^c.
  - Logic ops: bitwise result.
  - MOV: a.
- Carry register updates each EXEC cycle with the full-adder carry (b inverted for SUB/CMP).
- wr_en = EXEC && op writes. CMP never writes; NOP never writes.
- Flags update only on the DONE transition and hold until the next DONE:
  - flag_z: AND of the accumulated ~wr_bit over all bits.
  - flag_c: final carry for ADD/SUB/CMP/ADC; 0 for logic/MOV.
  - flag_n: last (MSB) result bit.
  - NOP leaves all flags unchanged.
- Reset values: state IDLE; shift_en, wr_en, wr_bit, busy, done = 0; flag_z, flag_c, flag_n = 0; counter 0.
- Reset mid-EXEC: next cycle is IDLE with shift_en=0, no done pulse, flags unchanged from their reset value (0).
- rst has priority over start in the same cycle.

Optional Feature:
Macro SERIAL_ALU_ADC_EN.
- Defined: op 111 = ADC. Carry-in is the current flag_c; the result is written; flags update like ADD.
- Undefined: op 111 = NOP. Runs the full REG_WIDTH shift cycles to keep regfile alignment, wr_en stays 0, done pulses, flags unchanged.

Test Plan:
- ADD rs1=0x3C, rs2=0x05, start at T -> wr_en high cycles T+1..T+8, serial wr_bits = 0x41, done at T+9, Z=0 C=0 N=0.
- SUB 0x10-0x10 -> result 0x00 written, Z=1 C=1 N=0; ADD 0xFF+0x01 -> 0x00, Z=1 C=1 N=0.
- CMP rs1=0x05, rs2=0x07 -> shift_en 8 cycles, wr_en never high, Z=0 C=0 N=1 (diff 0xFE); AND 0xF0&0x3C -> 0x30, C=0.
- start held high continuously -> ops accepted every 10 cycles only, exactly 8 shift_en per op; start pulsed during EXEC ignored.
- rst asserted at 4th EXEC cycle -> next cycle shift_en=0, busy=0, done never pulses, flags 0; a new start afterwards completes normally.
- Macro defined: after ADD 0xFF+0x01 (C=1), op 111 with 0x01,0x01 -> 0x03, C=0. Macro undefined: same stimulus -> wr_en never high, 8 shifts, done pulses, flags stay Z=1 C=1 N=0.

Source files
------------

// File: rtl/serial_alu_seq_if.sv
// serial_alu_seq_if: operand/result and handshake bundle between the serial
// register file side (master) and the bit-serial ALU sequencer (slave).
interface serial_alu_seq_if;
  logic       start;
  logic [2:0] op;
  logic       rs1_bit;
  logic       rs2_bit;
  logic       shift_en;
  logic       wr_bit;
  logic       wr_en;
  logic       busy;
  logic       done;
  logic       flag_z;
  logic       flag_c;
  logic       flag_n;

  modport master (
    output start, op, rs1_bit, rs2_bit,
    input  shift_en, wr_bit, wr_en, busy, done, flag_z, flag_c, flag_n
  );

  modport slave (
    input  start, op, rs1_bit, rs2_bit,
    output shift_en, wr_bit, wr_en, busy, done, flag_z, flag_c, flag_n
  );
endinterface

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial execute stage. Consumes rs1/rs2 LSB-first for
// exactly REG_WIDTH cycles per op, returns one result bit per cycle for
// writeback and latches Z/C/N flags when the op completes.
// Optional feature macro: SERIAL_ALU_ADC_EN (op 111 = ADC; otherwise NOP).
//
// state  | meaning
// S_IDLE | waiting for start, flags held
// S_EXEC | one shift and one result bit per cycle
// S_DONE | single-cycle done pulse, flags valid
module serial_alu_seq #(
  parameter  int REG_WIDTH = 8,
  localparam int CNT_W     = $clog2(REG_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  serial_alu_seq_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_X   = 3'b111;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REG_WIDTH - 1);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_n_q, flag_n_d;

  logic op_sub, op_arith, op_write, op_nop;
  logic b_eff, sum_bit, cout, res_bit, carry_preset;

  // Decode the latched op; op 111 is either ADC or a shift-only NOP.
  always_comb begin
    op_sub = (op_q == OP_SUB) || (op_q == OP_CMP);
`ifdef SERIAL_ALU_ADC_EN
    op_nop   = 1'b0;
    op_arith = (op_q == OP_ADD) || op_sub || (op_q == OP_X);
`else
    op_nop   = (op_q == OP_X);
    op_arith = (op_q == OP_ADD) || op_sub;
`endif
    op_write = (op_q != OP_CMP) && !op_nop;

    b_eff   = bus.rs2_bit ^ op_sub;
    sum_bit = bus.rs1_bit ^ b_eff ^ carry_q;
    cout    = (bus.rs1_bit & b_eff) | (carry_q & (bus.rs1_bit ^ b_eff));

    case (op_q)
      OP_ADD, OP_SUB, OP_CMP: res_bit = sum_bit;
      OP_AND:                 res_bit = bus.rs1_bit & bus.rs2_bit;
      OP_OR:                  res_bit = bus.rs1_bit | bus.rs2_bit;
      OP_XOR:                 res_bit = bus.rs1_bit ^ bus.rs2_bit;
      OP_MOV:                 res_bit = bus.rs1_bit;
`ifdef SERIAL_ALU_ADC_EN
      default:                res_bit = sum_bit;
`else
      default:                res_bit = 1'b0;
`endif
    endcase
  end

  // Carry preset for an incoming op: borrow-free for subtract, flag_c for ADC.
  always_comb begin
    carry_preset = (bus.op == OP_SUB) || (bus.op == OP_CMP);
`ifdef SERIAL_ALU_ADC_EN
    if (bus.op == OP_X) carry_preset = flag_c_q;
`endif
  end

  // Next-state logic; flags are captured on the last EXEC cycle so they are
  // valid during the done pulse.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    flag_n_d = flag_n_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_EXEC;
          op_d    = bus.op;
          cnt_d   = '0;
          carry_d = carry_preset;
          zacc_d  = 1'b1;
        end
      end
      S_EXEC: begin
        cnt_d   = cnt_q + CNT_W'(1);
        carry_d = cout;
        zacc_d  = zacc_q & ~res_bit;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          if (!op_nop) begin
            flag_z_d = zacc_q & ~res_bit;
            flag_c_d = op_arith & cout;
            flag_n_d = res_bit;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign bus.shift_en = (state_q == S_EXEC);
  assign bus.wr_en    = (state_q == S_EXEC) && op_write;
  assign bus.wr_bit   = (state_q == S_EXEC) && res_bit;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.flag_z   = flag_z_q;
  assign bus.flag_c   = flag_c_q;
  assign bus.flag_n   = flag_n_q;
endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: directed vectors for the bit-serial ALU sequencer plus
// hand-written sequences for held start, start during EXEC and mid-op reset.
module tb_serial_alu_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ra, rb;
  logic [2:0] bidx;
  int         errs = 0;
  int         checks = 0;

  serial_alu_seq_if bus ();

  serial_alu_seq #(.REG_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rs1_bit = ra[bidx];
  assign bus.rs2_bit = rb[bidx];

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    int         nwr;
    logic       z;
    logic       c;
    logic       n;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One op from start to the cycle after done; cycle k=1 is the first after acceptance.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int nwr, output int nsh,
                        output int dcyc, output int first_wr, output int last_wr,
                        output logic post_idle);
    logic sh;
    @(negedge clk);
    bus.op = op; ra = a; rb = b; bidx = 3'd0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    res = 8'h00; nwr = 0; nsh = 0; dcyc = -1; first_wr = -1; last_wr = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      sh = bus.shift_en;
      if (bus.wr_en) begin
        res[bidx] = bus.wr_bit;
        nwr++;
        if (first_wr < 0) first_wr = k;
        last_wr = k;
      end
      if (sh) nsh++;
      if (bus.done) begin
        dcyc = k;
        break;
      end
      @(posedge clk); #1;
      if (sh) bidx = bidx + 3'd1;
    end
    @(negedge clk);
    post_idle = !bus.done && !bus.busy && !bus.shift_en;
  endtask

  initial begin
    logic [7:0] res;
    int nwr, nsh, dcyc, fw, lw, nd, d2, nrise, rise2;
    logic post, prev;

    vecs.push_back('{"add_3c_05", 3'b000, 8'h3C, 8'h05, 8'h41, 8, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"sub_10_10", 3'b001, 8'h10, 8'h10, 8'h00, 8, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"cmp_05_07", 3'b110, 8'h05, 8'h07, 8'h00, 0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"and_f0_3c", 3'b010, 8'hF0, 8'h3C, 8'h30, 8, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"or_81_02",  3'b011, 8'h81, 8'h02, 8'h83, 8, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"xor_aa_aa", 3'b100, 8'hAA, 8'hAA, 8'h00, 8, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"mov_80",    3'b101, 8'h80, 8'h55, 8'h80, 8, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"sub_05_07", 3'b001, 8'h05, 8'h07, 8'hFE, 8, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"add_ff_01", 3'b000, 8'hFF, 8'h01, 8'h00, 8, 1'b1, 1'b1, 1'b0});
`ifdef SERIAL_ALU_ADC_EN
    vecs.push_back('{"adc_01_01", 3'b111, 8'h01, 8'h01, 8'h03, 8, 1'b0, 1'b0, 1'b0});
`else
    vecs.push_back('{"nop_01_01", 3'b111, 8'h01, 8'h01, 8'h00, 0, 1'b1, 1'b1, 1'b0});
`endif

    rst = 1'b1; bus.start = 1'b0; bus.op = 3'b000; ra = 8'h00; rb = 8'h00; bidx = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_shift_en", bus.shift_en, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_bit", bus.wr_bit, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_flag_z", bus.flag_z, 0);
    chk("rst_flag_c", bus.flag_c, 0);
    chk("rst_flag_n", bus.flag_n, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, nwr, nsh, dcyc, fw, lw, post);
      chk({vecs[i].name, "_done_cycle"}, dcyc, 9);
      chk({vecs[i].name, "_shifts"}, nsh, 8);
      chk({vecs[i].name, "_wr_count"}, nwr, vecs[i].nwr);
      if (vecs[i].nwr == 8) begin
        chk({vecs[i].name, "_result"}, res, vecs[i].res);
        chk({vecs[i].name, "_first_wr"}, fw, 1);
        chk({vecs[i].name, "_last_wr"}, lw, 8);
      end
      chk({vecs[i].name, "_flag_z"}, bus.flag_z, vecs[i].z);
      chk({vecs[i].name, "_flag_c"}, bus.flag_c, vecs[i].c);
      chk({vecs[i].name, "_flag_n"}, bus.flag_n, vecs[i].n);
      chk({vecs[i].name, "_idle_after"}, post, 1);
    end

    // start held high: accepted at edges 0, 10, 20 only
    @(negedge clk);
    bus.op = 3'b000; ra = 8'h00; rb = 8'h00; bidx = 3'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    nsh = 0; nd = 0; d2 = -1; nrise = 0; rise2 = -1; prev = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.shift_en) nsh++;
      if (bus.shift_en && !prev) begin
        nrise++;
        if (nrise == 2) rise2 = k;
      end
      prev = bus.shift_en;
      if (bus.done) begin
        nd++;
        if (nd == 2) d2 = k;
      end
    end
    bus.start = 1'b0;
    chk("held_shifts", nsh, 24);
    chk("held_dones", nd, 3);
    chk("held_ops", nrise, 3);
    chk("held_second_accept", rise2, 11);
    chk("held_second_done", d2, 19);
    repeat (3) @(negedge clk);

    // start pulse during EXEC must not queue a second op
    bus.op = 3'b000; ra = 8'h01; rb = 8'h01; bidx = 3'd0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    nsh = 0; nd = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.start = (k == 3);
      if (bus.shift_en) nsh++;
      if (bus.done) nd++;
    end
    bus.start = 1'b0;
    chk("pulse_shifts", nsh, 8);
    chk("pulse_dones", nd, 1);

    // reset on the 4th EXEC cycle
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.op = 3'b000; ra = 8'hFF; rb = 8'h01; bidx = 3'd0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    chk("midrst_in_exec", bus.shift_en, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_shift_en", bus.shift_en, 0);
    chk("midrst_busy", bus.busy, 0);
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("midrst_no_done", nd, 0);
    chk("midrst_flags", {bus.flag_z, bus.flag_c, bus.flag_n}, 3'b000);

    run_op(3'b000, 8'h3C, 8'h05, res, nwr, nsh, dcyc, fw, lw, post);
    chk("recover_result", res, 8'h41);
    chk("recover_done_cycle", dcyc, 9);
    chk("recover_shifts", nsh, 8);
    chk("recover_flags", {bus.flag_z, bus.flag_c, bus.flag_n}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
